ctr_seg_display: RTL and testbench

- Downstream consumer of the 4-bit mod-12 counter's ctr output.
- Registers the count and converts it to two decimal digits (tens 0/1, ones 0-9).
- Time-multiplexes both digits onto a common-anode two-digit seven-segment display.
- Detects the 11->0 rollover, emits a one-cycle wrap pulse, and keeps an AM/PM-style toggle flag for the next cascade stage.

---
 rtl/seg_pkg.sv | 19 +
 rtl/bin_to_seg.sv | 24 ++
 rtl/ctr_seg_display.sv | 69 ++++++
 tb/tb_ctr_seg_display.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment glyphs and anode encodings shared by the display logic.
// Glyphs are active-low {g,f,e,d,c,b,a}. Anodes are active-low {tens,ones}.
package seg_pkg;
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [1:0] AN_ONES     = 2'b10;
    localparam logic [1:0] AN_TENS     = 2'b01;
    localparam logic [1:0] AN_OFF      = 2'b11;
endpackage

// File: rtl/bin_to_seg.sv
// bin_to_seg: combinational decimal digit to active-low seven-segment decoder.
// Ports: digit (in, 4) value 0..9; seg (out, 7) glyph {g..a}, blank for digit > 9.
module bin_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        case (digit)
            4'd0:    seg = GLYPH_0;
            4'd1:    seg = GLYPH_1;
            4'd2:    seg = GLYPH_2;
            4'd3:    seg = GLYPH_3;
            4'd4:    seg = GLYPH_4;
            4'd5:    seg = GLYPH_5;
            4'd6:    seg = GLYPH_6;
            4'd7:    seg = GLYPH_7;
            4'd8:    seg = GLYPH_8;
            4'd9:    seg = GLYPH_9;
            default: seg = GLYPH_BLANK;
        endcase
    end
endmodule

// File: rtl/ctr_seg_display.sv
// ctr_seg_display: shows a mod-12 count on a multiplexed two-digit common-anode display,
// flags the 11->0 rollover and keeps an AM/PM toggle for the next cascade stage.
// Ports: clk (in) rising-edge clock; rst (in) async active-low reset; ctr (in, 4) count 0..11;
//        seg (out, 7) active-low segments {g..a}; an (out, 2) active-low anodes, an[0]=ones;
//        wrap (out) one-cycle rollover pulse; ampm (out) toggles per wrap; err (out) count >= 12.
module ctr_seg_display
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ctr,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       wrap,
    output logic       ampm,
    output logic       err
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

    logic [3:0]    ctr_q;
    logic [PW-1:0] pre;
    logic          sel;
    logic          tens;
    logic [3:0]    ones;
    logic [3:0]    digit;
    logic [6:0]    glyph;
    logic          bad;
    logic          blank;
    logic          roll;

    assign tens  = ctr_q >= 4'd10;
    assign ones  = tens ? ctr_q - 4'd10 : ctr_q;
    assign digit = sel ? {3'b000, tens} : ones;
    // bad mirrors err's next value so "E" appears in the same cycle err rises
    assign bad   = ctr_q >= 4'd12;
    assign blank = BLANK_LZ && sel && !tens && !bad;
    assign roll  = (ctr_q == 4'd11) && (ctr == 4'd0);

    bin_to_seg u_dec (
        .digit(digit),
        .seg  (glyph)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr_q <= '0;
            pre   <= '0;
            sel   <= 1'b0;
            seg   <= GLYPH_BLANK;
            an    <= AN_OFF;
            wrap  <= 1'b0;
            ampm  <= 1'b0;
            err   <= 1'b0;
        end else begin
            ctr_q <= ctr;
            pre   <= (pre == LAST) ? '0 : pre + 1'b1;
            if (pre == LAST) sel <= ~sel;
            wrap  <= roll;
            ampm  <= ampm ^ roll;
            err   <= bad;
            an    <= blank ? AN_OFF : (sel ? AN_TENS : AN_ONES);
            seg   <= blank ? GLYPH_BLANK : (bad ? GLYPH_E : glyph);
        end
    end
endmodule

// File: tb/tb_ctr_seg_display.sv
// tb_ctr_seg_display: directed bench with a spec-level model checked every cycle,
// plus hand-computed literal expectations. Two DUTs: BLANK_LZ=1 and BLANK_LZ=0.
module tb_ctr_seg_display;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ctr = 4'd7;
    logic [6:0] seg0, seg1;
    logic [1:0] an0, an1;
    logic       wrap0, wrap1, ampm0, ampm1, err0, err1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ctr_seg_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut0 (
        .clk(clk), .rst(rst), .ctr(ctr), .seg(seg0), .an(an0),
        .wrap(wrap0), .ampm(ampm0), .err(err0)
    );
    ctr_seg_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut1 (
        .clk(clk), .rst(rst), .ctr(ctr), .seg(seg1), .an(an1),
        .wrap(wrap1), .ampm(ampm1), .err(err1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] gl [10];
    initial gl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int         mq, mpre;
    logic       msel, mwrap, mampm, merr;
    logic [8:0] mdisp0, mdisp1;

    // {an, seg} a digit slot must show for count q
    function automatic logic [8:0] disp(input logic s, input int q, input logic blz);
        if (q >= 12) return {(s ? 2'b01 : 2'b10), 7'b0000110};
        if (!s) return {2'b10, gl[q % 10]};
        if (q / 10 == 0 && blz) return {2'b11, 7'h7F};
        return {2'b01, gl[q / 10]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq <= 0; mpre <= 0; msel <= 1'b0; mwrap <= 1'b0; mampm <= 1'b0; merr <= 1'b0;
            mdisp0 <= {2'b11, 7'h7F}; mdisp1 <= {2'b11, 7'h7F};
        end else begin
            mq     <= int'(ctr);
            mwrap  <= (mq == 11 && ctr == 0);
            mampm  <= mampm ^ (mq == 11 && ctr == 0);
            merr   <= mq >= 12;
            mpre   <= (mpre + 1) % DIV;
            msel   <= (mpre == DIV - 1) ? ~msel : msel;
            mdisp0 <= disp(msel, mq, 1'b1);
            mdisp1 <= disp(msel, mq, 1'b0);
        end
    end

    always @(negedge clk) begin
        chk("m_disp0", {an0, seg0}, mdisp0);
        chk("m_disp1", {an1, seg1}, mdisp1);
        chk("m_wrap0", wrap0, mwrap);
        chk("m_wrap1", wrap1, mwrap);
        chk("m_ampm0", ampm0, mampm);
        chk("m_ampm1", ampm1, mampm);
        chk("m_err0", err0, merr);
        chk("m_err1", err1, merr);
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // over 2*DIV cycles, each slot pattern must appear exactly DIV times
    task automatic scan(input string nm, input logic [8:0] o0, input logic [8:0] t0,
                        input logic [8:0] o1, input logic [8:0] t1);
        int a = 0, b = 0, c = 0, d = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            cyc();
            if ({an0, seg0} === o0) a++;
            else if ({an0, seg0} === t0) b++;
            if ({an1, seg1} === o1) c++;
            else if ({an1, seg1} === t1) d++;
        end
        chk({nm, "_ones0"}, a, DIV);
        chk({nm, "_tens0"}, b, DIV);
        chk({nm, "_ones1"}, c, DIV);
        chk({nm, "_tens1"}, d, DIV);
    endtask

    task automatic rollover(input logic exp_ampm);
        ctr = 4'd9;  cyc();
        ctr = 4'd10; cyc();
        ctr = 4'd11; cyc();
        chk("roll_pre_wrap", wrap0, 1'b0);
        ctr = 4'd0;  cyc();
        chk("roll_wrap", wrap0, 1'b1);
        chk("roll_ampm", ampm0, exp_ampm);
        ctr = 4'd1;  cyc();
        chk("roll_wrap_end", wrap0, 1'b0);
        chk("roll_ampm_hold", ampm0, exp_ampm);
    endtask

    initial begin
        // reset with ctr=7
        cyc();
        cyc();
        chk("rst_seg", seg0, 7'h7F);
        chk("rst_an", an0, 2'b11);
        chk("rst_ampm", ampm0, 1'b0);
        chk("rst_err", err0, 1'b0);
        rst = 1'b1;
        cyc();
        chk("first_an", an0, 2'b10);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ones7_an", an0, 2'b10);
            chk("ones7_seg", seg0, 7'b1111000);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("blank_an", an0, 2'b11);
            chk("blank_seg", seg0, 7'h7F);
            chk("lz_an", an1, 2'b01);
            chk("lz_seg", seg1, 7'b1000000);
        end
        // two-digit value 10
        ctr = 4'd10; cyc(); cyc();
        scan("ten", {2'b10, 7'b1000000}, {2'b01, 7'b1111001},
                    {2'b10, 7'b1000000}, {2'b01, 7'b1111001});
        // value 3: blanked vs leading zero
        ctr = 4'd3; cyc(); cyc();
        scan("three", {2'b10, 7'b0110000}, {2'b11, 7'h7F},
                      {2'b10, 7'b0110000}, {2'b01, 7'b1000000});
        // rollovers
        rollover(1'b1);
        rollover(1'b0);
        // non-wrap zeros
        ctr = 4'd5; cyc();
        ctr = 4'd0; cyc(); cyc();
        chk("zero5_wrap", wrap0, 1'b0);
        chk("zero5_ampm", ampm0, 1'b0);
        ctr = 4'd11; cyc();
        ctr = 4'd7; cyc(); cyc();
        chk("load7_wrap", wrap0, 1'b0);
        // illegal input 13
        ctr = 4'd13; cyc();
        chk("err_c1", err0, 1'b0);
        cyc();
        chk("err_c2", err0, 1'b1);
        scan("err", {2'b10, 7'b0000110}, {2'b01, 7'b0000110},
                    {2'b10, 7'b0000110}, {2'b01, 7'b0000110});
        ctr = 4'd4; cyc();
        chk("err_hold", err0, 1'b1);
        cyc();
        chk("err_clear", err0, 1'b0);
        // async reset mid-scan with ampm=1, sel=1
        rollover(1'b1);
        begin
            int k = 0;
            while (!(msel && mpre < DIV - 1) && k < 4 * DIV) begin cyc(); k++; end
            chk("sel_reached", k < 4 * DIV, 1'b1);
        end
        cyc();
        chk("pre_rst_ampm", ampm0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_an", an0, 2'b11);
        chk("arst_seg", seg0, 7'h7F);
        chk("arst_ampm", ampm0, 1'b0);
        chk("arst_err", err0, 1'b0);
        cyc();
        rst = 1'b1;
        for (int i = 0; i < DIV; i++) begin
            cyc();
            chk("resume_ones_an", an0, 2'b10);
        end
        cyc();
        chk("resume_tens_an", an1, 2'b01);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
